sobel_edge_detect_8bit: RTL and testbench



---
 rtl/sobel_edge_detect_8bit_if.sv | 30 +++
 rtl/sobel_edge_detect_8bit.sv | 73 +++++++
 tb/tb_sobel_edge_detect_8bit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sobel_edge_detect_8bit_if.sv
// sobel_edge_detect_8bit_if: 3x3 window stream in, delayed syncs and edge pixel out
interface sobel_edge_detect_8bit_if;
  logic        matrix_frame_vsync;
  logic        matrix_frame_href;
  logic        matrix_frame_clken;
  logic [7:0]  matrix_p11, matrix_p12, matrix_p13;
  logic [7:0]  matrix_p21, matrix_p22, matrix_p23;
  logic [7:0]  matrix_p31, matrix_p32, matrix_p33;
  logic [10:0] edge_threshold;
  logic        post_frame_vsync;
  logic        post_frame_href;
  logic        post_frame_clken;
  logic [7:0]  post_img_bit;
  modport slave (
    input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    input  edge_threshold,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
  );
  modport master (
    output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    output edge_threshold,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
  );
endinterface

// File: rtl/sobel_edge_detect_8bit.sv
// sobel_edge_detect_8bit: 3-stage Sobel edge detector with border masking.
// Define SOBEL_MAG_OUT_EN to output min(mag,255) instead of a thresholded 0x00/0xFF bit.
module sobel_edge_detect_8bit #(
  parameter int CNT_W = 12
) (
  input logic clk,
  input logic rst,
  sobel_edge_detect_8bit_if.slave io
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  logic [CNT_W-1:0] col_cnt, row_cnt;
  logic href_q, vsync_q;
  logic mask0, mask1, mask2;
  logic [2:0] sync1, sync2;
  logic [9:0] gx_p_c, gx_n_c, gy_p_c, gy_n_c;
  logic [9:0] gx_p, gx_n, gy_p, gy_n;
  logic [9:0] abs_gx, abs_gy;
  logic [10:0] mag;
  assign gx_p_c = {2'b0, io.matrix_p13} + {1'b0, io.matrix_p23, 1'b0} + {2'b0, io.matrix_p33};
  assign gx_n_c = {2'b0, io.matrix_p11} + {1'b0, io.matrix_p21, 1'b0} + {2'b0, io.matrix_p31};
  assign gy_p_c = {2'b0, io.matrix_p31} + {1'b0, io.matrix_p32, 1'b0} + {2'b0, io.matrix_p33};
  assign gy_n_c = {2'b0, io.matrix_p11} + {1'b0, io.matrix_p12, 1'b0} + {2'b0, io.matrix_p13};
  // href low means col_cnt is about to clear, so such a pixel is always masked
  assign mask0 = !io.matrix_frame_href || col_cnt < CNT_TWO || row_cnt < CNT_TWO;
  assign mag = {1'b0, abs_gx} + {1'b0, abs_gy};
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      href_q  <= io.matrix_frame_href;
      vsync_q <= io.matrix_frame_vsync;
      col_cnt <= !io.matrix_frame_href ? '0 :
                 (io.matrix_frame_clken && col_cnt != CNT_MAX) ? col_cnt + 1'b1 : col_cnt;
      row_cnt <= (io.matrix_frame_vsync && !vsync_q) ? '0 :
                 (href_q && !io.matrix_frame_href && row_cnt != CNT_MAX) ? row_cnt + 1'b1 : row_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {gx_p, gx_n, gy_p, gy_n} <= '0;
      {abs_gx, abs_gy} <= '0;
      {mask1, mask2} <= '0;
      {sync1, sync2} <= '0;
      io.post_frame_vsync <= 1'b0;
      io.post_frame_href  <= 1'b0;
      io.post_frame_clken <= 1'b0;
      io.post_img_bit     <= 8'h00;
    end else begin
      gx_p  <= gx_p_c;
      gx_n  <= gx_n_c;
      gy_p  <= gy_p_c;
      gy_n  <= gy_n_c;
      mask1 <= mask0;
      sync1 <= {io.matrix_frame_vsync, io.matrix_frame_href, io.matrix_frame_clken};
      abs_gx <= (gx_p >= gx_n) ? gx_p - gx_n : gx_n - gx_p;
      abs_gy <= (gy_p >= gy_n) ? gy_p - gy_n : gy_n - gy_p;
      mask2  <= mask1;
      sync2  <= sync1;
      io.post_frame_vsync <= sync2[2];
      io.post_frame_href  <= sync2[1];
      io.post_frame_clken <= sync2[0];
`ifdef SOBEL_MAG_OUT_EN
      io.post_img_bit <= mask2 ? 8'h00 : (mag > 11'd255) ? 8'hFF : mag[7:0];
`else
      io.post_img_bit <= (mask2 || mag <= io.edge_threshold) ? 8'h00 : 8'hFF;
`endif
    end
  end
endmodule

// File: tb/tb_sobel_edge_detect_8bit.sv
// tb_sobel_edge_detect_8bit: directed checks of latency, thresholding, abs paths and border masking.
module tb_sobel_edge_detect_8bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sobel_edge_detect_8bit_if bus();
  sobel_edge_detect_8bit #(.CNT_W(12)) dut (.clk(clk), .rst(rst), .io(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic [10:0] exq [3];
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask
  task automatic set_win(input logic [7:0] a, b, c, d, e, f, g, h, i);
    bus.matrix_p11 = a; bus.matrix_p12 = b; bus.matrix_p13 = c;
    bus.matrix_p21 = d; bus.matrix_p22 = e; bus.matrix_p23 = f;
    bus.matrix_p31 = g; bus.matrix_p32 = h; bus.matrix_p33 = i;
  endtask
  task automatic clear_exp();
    for (int k = 0; k < 3; k++) exq[k] = '0;
  endtask
  // eb: expected binary output, em: expected saturated magnitude output
  task automatic step(input logic v, h, c, input logic [7:0] eb, input logic [7:0] em);
    logic [7:0] e;
`ifdef SOBEL_MAG_OUT_EN
    e = em;
`else
    e = eb;
`endif
    bus.matrix_frame_vsync = v;
    bus.matrix_frame_href  = h;
    bus.matrix_frame_clken = c;
    exq[2] = exq[1];
    exq[1] = exq[0];
    exq[0] = {v, h, c, e};
    @(negedge clk);
    check("post_vsync", {7'b0, bus.post_frame_vsync}, {7'b0, exq[2][10]});
    check("post_href",  {7'b0, bus.post_frame_href},  {7'b0, exq[2][9]});
    check("post_clken", {7'b0, bus.post_frame_clken}, {7'b0, exq[2][8]});
    if (exq[2][8]) check("post_img_bit", bus.post_img_bit, exq[2][7:0]);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask
  task automatic vsync_pulse();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(2);
  endtask
  task automatic line(input int n, input logic row_ok, input logic [7:0] eb, input logic [7:0] em);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'b1, 1'b1, (row_ok && k >= 2) ? eb : 8'h00, (row_ok && k >= 2) ? em : 8'h00);
    idle(3);
  endtask
  // idle tail keeps a new threshold from reaching stage 3 before the last valid pixel
  task automatic seg(input logic [10:0] thr, input int n, input logic [7:0] eb, input logic [7:0] em);
    bus.edge_threshold = thr;
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b1, eb, em);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    @(negedge clk);
    check("rst_vsync", {7'b0, bus.post_frame_vsync}, 8'h00);
    check("rst_href",  {7'b0, bus.post_frame_href},  8'h00);
    check("rst_clken", {7'b0, bus.post_frame_clken}, 8'h00);
    check("rst_img",   bus.post_img_bit, 8'h00);
    rst = 1'b0;
    clear_exp();
  endtask
  initial begin
    bus.matrix_frame_vsync = 1'b0;
    bus.matrix_frame_href  = 1'b0;
    bus.matrix_frame_clken = 1'b0;
    bus.edge_threshold     = 11'd0;
    set_win(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_pulse();
    // border masking over a 3-line frame of strong vertical edges
    set_win(0, 128, 255, 0, 128, 255, 0, 128, 255);
    bus.edge_threshold = 11'd500;
    vsync_pulse();
    line(6, 1'b0, 8'hFF, 8'hFF);
    line(6, 1'b0, 8'hFF, 8'hFF);
    line(6, 1'b1, 8'hFF, 8'hFF);
    // line 3: past the border, one window/threshold pair per segment
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    set_win(100, 100, 100, 100, 100, 100, 100, 100, 100);
    seg(11'd10, 4, 8'h00, 8'h00);
    set_win(0, 128, 255, 0, 128, 255, 0, 128, 255);
    seg(11'd500, 3, 8'hFF, 8'hFF);
    seg(11'd1020, 3, 8'h00, 8'hFF);
    set_win(255, 128, 0, 255, 128, 0, 255, 128, 0);
    seg(11'd1019, 3, 8'hFF, 8'hFF);
    seg(11'd1020, 3, 8'h00, 8'hFF);
    set_win(0, 0, 0, 128, 128, 128, 255, 255, 255);
    seg(11'd1019, 3, 8'hFF, 8'hFF);
    set_win(255, 255, 255, 128, 128, 128, 0, 0, 0);
    seg(11'd1019, 3, 8'hFF, 8'hFF);
    seg(11'd1020, 3, 8'h00, 8'hFF);
    set_win(0, 0, 0, 0, 0, 0, 0, 0, 255);
    seg(11'd0, 3, 8'hFF, 8'hFF);
    seg(11'd509, 3, 8'hFF, 8'hFF);
    seg(11'd510, 3, 8'h00, 8'hFF);
    set_win(255, 0, 0, 0, 0, 0, 0, 0, 0);
    seg(11'd509, 3, 8'hFF, 8'hFF);
    seg(11'd510, 3, 8'h00, 8'hFF);
    set_win(0, 0, 0, 0, 0, 100, 0, 0, 0);
    seg(11'd199, 3, 8'hFF, 8'hC8);
    seg(11'd200, 3, 8'h00, 8'hC8);
    set_win(0, 0, 0, 0, 0, 0, 0, 50, 0);
    seg(11'd99, 3, 8'hFF, 8'h64);
    seg(11'd100, 3, 8'h00, 8'h64);
    idle(3);
    // line 4: reset mid-line with edge pixels in flight
    set_win(0, 128, 255, 0, 128, 255, 0, 128, 255);
    bus.edge_threshold = 11'd500;
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    rst_pulse();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    idle(3);
    line(6, 1'b0, 8'hFF, 8'hFF);
    vsync_pulse();
    line(6, 1'b0, 8'hFF, 8'hFF);
    line(6, 1'b0, 8'hFF, 8'hFF);
    line(6, 1'b1, 8'hFF, 8'hFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
